// File: rtl/processing_element_array.sv
// Weight-stationary systolic array of NUM_ROWS x NUM_COLS multiply-accumulate PEs.
// Activations flow left to right, partial sums flow top to bottom, and one global advance stalls the whole grid.
module processing_element_array #(
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BIT_WIDTH:0]   i_msg_recv_msg [NUM_ROWS],
  input  logic [NUM_ROWS-1:0]  i_msg_recv_val,
  output logic [NUM_ROWS-1:0]  o_msg_recv_rdy,
  output logic [BIT_WIDTH-1:0] o_prod_send_msg [NUM_COLS],
  output logic [NUM_COLS-1:0]  o_prod_send_val,
  input  logic [NUM_COLS-1:0]  i_prod_send_rdy
);

  logic [BIT_WIDTH-1:0] w_q [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] w_d [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] a_q [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] a_d [NUM_ROWS][NUM_COLS];
  logic                 av_q [NUM_ROWS][NUM_COLS];
  logic                 av_d [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] p_q [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] p_d [NUM_ROWS][NUM_COLS];
  logic                 pv_q [NUM_ROWS][NUM_COLS];
  logic                 pv_d [NUM_ROWS][NUM_COLS];

  logic [BIT_WIDTH-1:0] in_data  [NUM_ROWS][NUM_COLS];
  logic                 in_val   [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] w_shift  [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] psum_up  [NUM_ROWS][NUM_COLS];
  logic                 pv_up    [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] prod     [NUM_ROWS][NUM_COLS];
  logic [BIT_WIDTH-1:0] psum     [NUM_ROWS][NUM_COLS];

  logic [BIT_WIDTH-1:0] inj_data [NUM_ROWS];
  logic                 inj_val  [NUM_ROWS];
  logic                 wgt_load [NUM_ROWS];
  logic                 adv;

  // A column holding a result its consumer will not take freezes every register in the grid.
  assign adv            = &(~o_prod_send_val | i_prod_send_rdy);
  assign o_msg_recv_rdy = {NUM_ROWS{adv & i_rst}};

  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
    logic accept;
    assign accept        = i_msg_recv_val[gr] & adv;
    assign wgt_load[gr]  = accept & i_msg_recv_msg[gr][BIT_WIDTH];
    assign inj_val[gr]   = accept & ~i_msg_recv_msg[gr][BIT_WIDTH];
    assign inj_data[gr]  = inj_val[gr] ? i_msg_recv_msg[gr][BIT_WIDTH-1:0] : '0;
  end

  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_pe_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_pe_col
      if (gc == 0) begin : g_left_edge
        assign in_val[gr][gc]  = inj_val[gr];
        assign in_data[gr][gc] = inj_data[gr];
        assign w_shift[gr][gc] = i_msg_recv_msg[gr][BIT_WIDTH-1:0];
      end else begin : g_inner_col
        assign in_val[gr][gc]  = av_q[gr][gc-1];
        assign in_data[gr][gc] = a_q[gr][gc-1];
        assign w_shift[gr][gc] = w_q[gr][gc-1];
      end

      // Row 0 starts a fresh sum; lower rows extend the sum from the PE directly above.
      if (gr == 0) begin : g_top_edge
        assign psum_up[gr][gc] = '0;
        assign pv_up[gr][gc]   = 1'b1;
      end else begin : g_inner_row
        assign psum_up[gr][gc] = p_q[gr-1][gc];
        assign pv_up[gr][gc]   = pv_q[gr-1][gc];
      end

      assign prod[gr][gc] = in_val[gr][gc] ? in_data[gr][gc] * w_q[gr][gc] : '0;
      assign psum[gr][gc] = prod[gr][gc] + psum_up[gr][gc];
    end
  end

  always_comb begin
    w_d  = w_q;
    a_d  = a_q;
    av_d = av_q;
    p_d  = p_q;
    pv_d = pv_q;
    if (adv) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (wgt_load[r]) begin
            w_d[r][c] = w_shift[r][c];
          end
          a_d[r][c]  = in_data[r][c];
          av_d[r][c] = in_val[r][c];
          p_d[r][c]  = psum[r][c];
          pv_d[r][c] = in_val[r][c] & pv_up[r][c];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          w_q[r][c]  <= '0;
          a_q[r][c]  <= '0;
          av_q[r][c] <= 1'b0;
          p_q[r][c]  <= '0;
          pv_q[r][c] <= 1'b0;
        end
      end
    end else begin
      w_q  <= w_d;
      a_q  <= a_d;
      av_q <= av_d;
      p_q  <= p_d;
      pv_q <= pv_d;
    end
  end

  for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_out
    assign o_prod_send_msg[gc] = p_q[NUM_ROWS-1][gc];
    assign o_prod_send_val[gc] = pv_q[NUM_ROWS-1][gc];
  end

endmodule

// File: tb/tb_processing_element_array.sv
// Bench for processing_element_array: directed 2x2 scenarios plus randomized skewed vectors
// checked against a dot-product model scheduled by advance-step count.
module tb_processing_element_array;

  localparam int R    = 2;
  localparam int C    = 2;
  localparam int BW   = 8;
  localparam int MAXV = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW:0]   recv_msg [R];
  logic [R-1:0]  recv_val;
  logic [R-1:0]  recv_rdy;
  logic [BW-1:0] prod_msg [C];
  logic [C-1:0]  prod_val;
  logic [C-1:0]  prod_rdy;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] w_model  [R][C];
  logic [BW-1:0] vec_data [MAXV][R];
  int            vec_start [MAXV];
  int            n_vec = 0;

  always #5 clk = ~clk;

  processing_element_array #(
    .NUM_ROWS (R),
    .NUM_COLS (C),
    .BIT_WIDTH(BW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_msg_recv_msg (recv_msg),
    .i_msg_recv_val (recv_val),
    .o_msg_recv_rdy (recv_rdy),
    .o_prod_send_msg(prod_msg),
    .o_prod_send_val(prod_val),
    .i_prod_send_rdy(prod_rdy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Row r carries element r of vector k exactly r advance steps after row 0 saw it; otherwise idle garbage.
  task automatic applyStimulus(input int step);
    for (int r = 0; r < R; r++) begin
      recv_val[r] = 1'b0;
      recv_msg[r] = {1'($urandom_range(1)), BW'($urandom)};
      for (int k = 0; k < n_vec; k++) begin
        if (vec_start[k] + r == step) begin
          recv_val[r] = 1'b1;
          recv_msg[r] = {1'b0, vec_data[k][r]};
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] dotCol(input int k, input int c);
    int acc = 0;
    for (int r = 0; r < R; r++) acc += int'(vec_data[k][r]) * int'(w_model[r][c]);
    return BW'(acc);
  endfunction

  // Message j on a row ends up NUM_COLS-1-j columns to the right.
  task automatic loadWeights();
    for (int j = 0; j < C; j++) begin
      @(negedge clk);
      prod_rdy = '1;
      for (int r = 0; r < R; r++) begin
        recv_val[r] = 1'b1;
        recv_msg[r] = {1'b1, w_model[r][C-1-j]};
      end
      #1;
      checkOutput("load_rdy", 32'(recv_rdy), 32'({R{1'b1}}));
      checkOutput("load_val", 32'(prod_val), 32'd0);
    end
    @(negedge clk);
    recv_val = '0;
  endtask

  task automatic streamVectors(input int stall_cycles, input int rdy_pct);
    int            done = 0;
    int            cycles = 0;
    int            last;
    int            stall_left = stall_cycles;
    logic [C-1:0]  exp_val;
    logic [BW-1:0] exp_msg [C];
    logic          exp_adv;
    last = (n_vec > 0) ? vec_start[n_vec-1] : 0;
    while (done <= last + R + C) begin
      @(negedge clk);
      exp_val = '0;
      for (int c = 0; c < C; c++) begin
        exp_msg[c] = '0;
        for (int k = 0; k < n_vec; k++) begin
          if (vec_start[k] + R + c == done) begin
            exp_val[c] = 1'b1;
            exp_msg[c] = dotCol(k, c);
          end
        end
        prod_rdy[c] = ($urandom_range(99) < rdy_pct);
      end
      if (exp_val[0] && stall_left > 0) begin
        prod_rdy[0] = 1'b0;
        stall_left--;
      end
      applyStimulus(done);
      #1;
      exp_adv = &(~exp_val | prod_rdy);
      checkOutput($sformatf("val@%0d", done), 32'(prod_val), 32'(exp_val));
      for (int c = 0; c < C; c++) begin
        if (exp_val[c]) checkOutput($sformatf("msg%0d@%0d", c, done), 32'(prod_msg[c]), 32'(exp_msg[c]));
      end
      checkOutput($sformatf("recv_rdy@%0d", done), 32'(recv_rdy), 32'({R{exp_adv}}));
      @(posedge clk);
      if (exp_adv) done++;
      cycles++;
      if (cycles > 2000) begin
        checkOutput("stream_timeout", done, last + R + C + 1);
        break;
      end
    end
    @(negedge clk);
    recv_val = '0;
    prod_rdy = '1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    recv_val = '0;
    prod_rdy = '1;
    for (int r = 0; r < R; r++) recv_msg[r] = '0;

    #12;
    checkOutput("reset_val", 32'(prod_val), 32'd0);
    checkOutput("reset_msg0", 32'(prod_msg[0]), 32'd0);
    checkOutput("reset_msg1", 32'(prod_msg[1]), 32'd0);
    checkOutput("reset_rdy", 32'(recv_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_reset", 32'(recv_rdy), 32'({R{1'b1}}));

    // Idle: nothing offered, consumers ready
    repeat (8) begin
      @(negedge clk);
      recv_val = '0;
      prod_rdy = '1;
      #1;
      checkOutput("idle_val", 32'(prod_val), 32'd0);
      checkOutput("idle_rdy", 32'(recv_rdy), 32'({R{1'b1}}));
    end

    // Directed MAC: weights 2/3/4/5, vector (1,6) gives 26 and 33
    w_model = '{'{8'd2, 8'd3}, '{8'd4, 8'd5}};
    loadWeights();
    n_vec = 1;
    vec_data[0] = '{8'd1, 8'd6};
    vec_start[0] = 0;
    streamVectors(0, 100);

    // Same vector again, weights persist; column 0 consumer stalls for three cycles
    streamVectors(3, 100);

    // Overflow wraps modulo 2^BW
    w_model = '{'{8'd16, 8'd16}, '{8'd16, 8'd16}};
    loadWeights();
    vec_data[0] = '{8'd16, 8'd0};
    streamVectors(0, 100);

    // Reset in the middle of a computation
    w_model = '{'{8'd2, 8'd3}, '{8'd4, 8'd5}};
    loadWeights();
    @(negedge clk);
    prod_rdy = '1;
    recv_val = 2'b01;
    recv_msg[0] = {1'b0, 8'd1};
    @(negedge clk);
    recv_val = 2'b10;
    recv_msg[1] = {1'b0, 8'd6};
    @(negedge clk);
    recv_val = '0;
    #1;
    checkOutput("pre_reset_val0", 32'(prod_val[0]), 32'd1);
    checkOutput("pre_reset_msg0", 32'(prod_msg[0]), 32'd26);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_val", 32'(prod_val), 32'd0);
    checkOutput("midreset_msg0", 32'(prod_msg[0]), 32'd0);
    checkOutput("midreset_msg1", 32'(prod_msg[1]), 32'd0);
    checkOutput("midreset_rdy", 32'(recv_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w_model = '{'{8'd0, 8'd0}, '{8'd0, 8'd0}};
    vec_data[0] = '{8'd1, 8'd6};
    streamVectors(0, 100);

    // Randomized weights, vectors, spacing and consumer backpressure
    repeat (4) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) w_model[r][c] = BW'($urandom);
      loadWeights();
      n_vec = 12;
      begin
        int s = 0;
        for (int k = 0; k < n_vec; k++) begin
          vec_start[k] = s;
          s += $urandom_range(1, 3);
          for (int r = 0; r < R; r++) vec_data[k][r] = BW'($urandom);
        end
      end
      streamVectors(0, 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/processing_element_array.md
PROCESSING_ELEMENT_ARRAY -- requirements
Module: processing_element_array

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_ROWS, default 2, number of PE rows (>=1)
  NUM_COLS, default 2, number of PE columns (>=1)
  BIT_WIDTH, default 8, data/weight/product width
REQ-002 Ports SHALL be, one per line (clock and reset first):
  i_clk  input  1  single clock; all state on rising edge
  i_rst  input  1  reset, asynchronous, active-low
  i_msg_recv_msg  input  [BIT_WIDTH:0] x NUM_ROWS (unpacked)  per-row message; bit BIT_WIDTH = is_weight, [BIT_WIDTH-1:0] = data
  i_msg_recv_val  input  NUM_ROWS  per-row message valid
  o_msg_recv_rdy  output  NUM_ROWS  per-row ready
  o_prod_send_msg  output  [BIT_WIDTH-1:0] x NUM_COLS (unpacked)  per-column result
  o_prod_send_val  output  NUM_COLS  per-column result valid
  i_prod_send_rdy  input  NUM_COLS  per-column consumer ready

Function
REQ-003 Array SHALL be a weight-stationary systolic grid of NUM_ROWS x NUM_COLS PEs, each holding weight W(r,c), activation register A(r,c)+valid AV(r,c), partial-sum register P(r,c)+valid PV(r,c).
REQ-004 Global advance SHALL be adv = AND over c of (!o_prod_send_val[c] | i_prod_send_rdy[c]); all registers update only when adv=1, else hold.
REQ-005 o_msg_recv_rdy[r] SHALL equal adv for every row while out of reset; a row message is accepted when val & rdy.
REQ-006 Accepted weight message (is_weight=1) on row r SHALL shift the row weight chain: W(r,0) <= data, W(r,c) <= W(r,c-1); after NUM_COLS weight messages the first one sent sits in W(r,NUM_COLS-1).
REQ-007 Incoming activation to PE(r,0) SHALL be the accepted non-weight data with valid=1; a weight message or no accepted message SHALL inject a bubble (valid=0, value 0); incoming to PE(r,c>0) SHALL be A(r,c-1)/AV(r,c-1).
REQ-008 On adv: A(r,c) <= incoming; AV(r,c) <= incoming valid; P(r,c) <= (incoming valid ? incoming*W(r,c) : 0) + (r>0 ? P(r-1,c) : 0); PV(r,c) <= incoming valid & (r==0 | PV(r-1,c)).
REQ-009 Arithmetic SHALL be unsigned, truncated modulo 2^BIT_WIDTH at every multiply and add.
REQ-010 o_prod_send_msg[c] SHALL be P(NUM_ROWS-1,c); o_prod_send_val[c] SHALL be PV(NUM_ROWS-1,c); both held stable while adv=0.
REQ-011 Input skew is caller responsibility: row r activation for one vector SHALL be presented r advance-steps after row 0; column c result valid after advance step t0+(NUM_ROWS-1)+c, t0 = row-0 injection step.
REQ-012 Any column with val=1 and rdy=0 SHALL stall the whole array (all rows rdy=0, no weight or data accepted).
REQ-013 Weights SHALL persist across any number of data vectors until overwritten or reset.
REQ-014 Weight and data messages on different rows in the same cycle SHALL both be accepted independently.

Reset
REQ-015 While i_rst=0 (asynchronously), all W, A, AV, P, PV SHALL clear to 0; o_prod_send_val=0, o_prod_send_msg=0, o_msg_recv_rdy=0.
REQ-016 First rising edge after i_rst deasserts SHALL see o_msg_recv_rdy all 1; reset mid-operation SHALL discard all in-flight results and weights.

Verification
REQ-017 Weight load 2x2/BW=8: row0 sends weights 3 then 2, row1 sends 5 then 4 -> W(0,0)=2, W(0,1)=3, W(1,0)=4, W(1,1)=5; no o_prod_send_val during load.
REQ-018 MAC: after REQ-017, row0 data 1 at step t, row1 data 6 at step t+1, all rdy=1 -> col0 = 26 valid after step t+1, col1 = 33 valid after step t+2, each val for exactly one cycle.
REQ-019 Overflow: all weights 16, row0 data 16, row1 data 0 skewed -> col0/col1 result 0 (256 mod 256).
REQ-020 Backpressure: i_prod_send_rdy[0]=0 when col0 valid -> o_msg_recv_rdy=00, col0 value/val held, col1 frozen; release rdy -> pipeline resumes, col1 = 33 next step.
REQ-021 Reset mid-op: assert i_rst=0 between REQ-018 steps -> outputs immediately val=0/msg=0; after release, data without reload yields 0 results (weights cleared).
REQ-022 Idle: all val=0, rdy=1 -> o_prod_send_val stays 00, o_msg_recv_rdy stays 11.
